// File: rtl/csc_gather_pkg.sv
// Shared types and constants for the gather scheduler slice.
package csc_gather_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 6;
  // Wide enough for the largest supported requester count (8).
  localparam int unsigned IDW   = 3;

  typedef logic [DW-1:0]          lane_t;
  typedef lane_t [LANES-1:0]      batch_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } sched_state_e;

  typedef struct packed {
    logic [IDW-1:0] id;
    batch_t         data;
  } resp_t;

endpackage

// File: rtl/csc_gather_fifo.sv
// First-word-fall-through response FIFO holding {id, batch} entries.
module csc_gather_fifo
  import csc_gather_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  resp_t         din,
  input  logic          pop,
  output resp_t         dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_t           mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; push and pop in one cycle keep count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/csc_gather_sched.sv
// Round-robin scheduler sharing one gather datapath among NREQ requesters.
module csc_gather_sched
  import csc_gather_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned LAT    = 1,
  parameter int unsigned FDEPTH = 4,
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_vld,
  input  logic [NREQ*LANES*DW-1:0]    req_data,
  output logic [NREQ-1:0]             req_rdy,
  output logic [LANES*DW-1:0]         g_a,
  input  logic [LANES*DW-1:0]         g_b,
  output logic                        resp_vld,
  input  logic                        resp_rdy,
  output logic [IW-1:0]               resp_id,
  output logic [LANES*DW-1:0]         resp_data,
  input  logic                        flush,
  output logic                        flush_done,
  output logic                        busy
);

  localparam int unsigned BW  = LANES * DW;
  localparam int unsigned IFW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int unsigned FCW = $clog2(FDEPTH + 1);

  sched_state_e    state, state_nxt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   winner;
  logic            found;
  logic            credit_ok;
  logic            issue;
  logic [LAT-1:0]  tag_vld;
  logic [IW-1:0]   tag_id [LAT];
  logic [IFW-1:0]  inflight;
  logic            push;
  logic            pop;
  resp_t           push_ent;
  resp_t           head;
  logic [FCW-1:0]  fifo_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            id_hi_unused;

  // Round-robin search: first requester above last_grant, else lowest index.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && req_vld[j] && (j > 32'(last_grant))) begin
        found  = 1'b1;
        winner = IW'(j);
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && req_vld[j]) begin
        found  = 1'b1;
        winner = IW'(j);
      end
    end
  end

  // Registered counts only: a pop in this cycle does not free a credit yet.
  assign credit_ok = (32'(fifo_cnt) + 32'(inflight)) < FDEPTH;
  assign issue     = !rst && (state == RUN) && found && credit_ok;

  // One-hot grant and datapath operand select.
  always_comb begin
    req_rdy = '0;
    g_a     = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (issue && (winner == IW'(j))) begin
        req_rdy[j] = 1'b1;
        g_a        = req_data[j*BW +: BW];
      end
    end
  end

  // Priority pointer moves to the winner only when a batch is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_grant <= IW'(NREQ - 1);
    else if (issue) last_grant <= winner;
  end

  // Tag pipe tracks requester IDs alongside the gather pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int unsigned k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld[0] <= issue;
      tag_id[0]  <= winner;
      for (int unsigned k = 1; k < LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  assign push          = tag_vld[LAT-1];
  assign push_ent.id   = IDW'(tag_id[LAT-1]);
  assign push_ent.data = g_b;
  assign pop           = resp_vld & resp_rdy;

  // Batches issued but not yet captured by the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({issue, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  csc_gather_fifo #(
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .dout  (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign resp_vld  = !fifo_empty;
  assign resp_id   = fifo_empty ? '0 : IW'(head.id);
  assign resp_data = fifo_empty ? '0 : head.data;
  assign busy      = (inflight != '0) || !fifo_empty;
  // Upper ID bits beyond IW are always zero.
  assign id_hi_unused = ^head.id;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Flush sequencing: stop issuing, wait for empty, pulse done.
  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if ((inflight == '0) && fifo_empty) state_nxt = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Credits make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full))
    else $error("response FIFO overflow");

endmodule

// File: tb/tb_csc_gather_sched.sv
// Directed bench for csc_gather_sched (NREQ=2, LAT=1, FDEPTH=4).
module tb_csc_gather_sched;
  import csc_gather_pkg::*;

  localparam int BW = LANES * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_vld;
  logic [2*BW-1:0] req_data;
  logic [1:0]      req_rdy;
  logic [BW-1:0]   g_a;
  logic [BW-1:0]   g_b;
  logic            resp_vld;
  logic            resp_rdy;
  logic            resp_id;
  logic [BW-1:0]   resp_data;
  logic            flush;
  logic            flush_done;
  logic            busy;

  int n_vec = 0;
  int n_bad = 0;
  int k     = 0;

  typedef struct packed {
    logic          id;
    logic [BW-1:0] d;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [1:0]    vld;
    logic          rr;
    logic [1:0]    e_rdy;
    logic [BW-1:0] e_ga;
    logic          e_rv;
    logic          e_id;
    logic [BW-1:0] e_rd;
    logic          e_busy;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  csc_gather_sched #(
    .NREQ   (2),
    .LAT    (1),
    .FDEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_data   (req_data),
    .req_rdy    (req_rdy),
    .g_a        (g_a),
    .g_b        (g_b),
    .resp_vld   (resp_vld),
    .resp_rdy   (resp_rdy),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy)
  );

  // Gather datapath stand-in: reverse lanes, add 1 per lane, one-cycle latency.
  function automatic logic [BW-1:0] gf(input logic [BW-1:0] x);
    logic [BW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*DW +: DW] = x[(3-i)*DW +: DW] + 6'd1;
    return r;
  endfunction

  logic [BW-1:0] gb_q = '0;
  always @(posedge clk) gb_q <= gf(g_a);
  assign g_b = gb_q;

  function automatic logic [BW-1:0] mk(input int l0, input int l1, input int l2, input int l3);
    return {6'(l3), 6'(l2), 6'(l1), 6'(l0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0();
    req_data[BW-1:0] = mk(k, k + 7, k * 3, 63 - k);
  endtask

  // Compare the head against the scoreboard and record any grant made now.
  task automatic sb_sample();
    if (resp_vld) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 32'(resp_vld), 32'd0);
      end else begin
        chk("sb_id", 32'(resp_id), 32'(exp_q[0].id));
        chk("sb_data", 32'(resp_data), 32'(exp_q[0].d));
        if (resp_rdy) void'(exp_q.pop_front());
      end
    end
    if (req_rdy[0]) exp_q.push_back('{id: 1'b0, d: gf(req_data[0 +: BW])});
    if (req_rdy[1]) exp_q.push_back('{id: 1'b1, d: gf(req_data[BW +: BW])});
  endtask

  task automatic drain(input int maxc);
    req_vld  = 2'b00;
    resp_rdy = 1'b1;
    for (int c = 0; c < maxc && (exp_q.size() != 0 || busy); c++) begin
      #3;
      sb_sample();
      next();
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    #3;
    chk("drain_busy", 32'(busy), 32'd0);
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [BW-1:0] ba, bb, ga, gbx;
    int nissue;
    ba  = mk(0, 4, 0, 3);
    bb  = mk(1, 2, 3, 4);
    ga  = mk(4, 1, 5, 1);
    gbx = mk(5, 4, 3, 2);

    //           vld    rr    e_rdy  e_ga e_rv  e_id  e_rd  e_busy
    tbl[0]  = '{2'b00, 1'b1, 2'b00, '0,  1'b0, 1'b0, '0,  1'b0};
    tbl[1]  = '{2'b01, 1'b1, 2'b01, ba,  1'b0, 1'b0, '0,  1'b0};
    tbl[2]  = '{2'b00, 1'b1, 2'b00, '0,  1'b0, 1'b0, '0,  1'b1};
    tbl[3]  = '{2'b00, 1'b1, 2'b00, '0,  1'b1, 1'b0, ga,  1'b1};
    tbl[4]  = '{2'b00, 1'b1, 2'b00, '0,  1'b0, 1'b0, '0,  1'b0};
    tbl[5]  = '{2'b11, 1'b1, 2'b10, bb,  1'b0, 1'b0, '0,  1'b0};
    tbl[6]  = '{2'b11, 1'b1, 2'b01, ba,  1'b0, 1'b0, '0,  1'b1};
    tbl[7]  = '{2'b11, 1'b1, 2'b10, bb,  1'b1, 1'b1, gbx, 1'b1};
    tbl[8]  = '{2'b11, 1'b1, 2'b01, ba,  1'b1, 1'b0, ga,  1'b1};
    tbl[9]  = '{2'b00, 1'b1, 2'b00, '0,  1'b1, 1'b1, gbx, 1'b1};
    tbl[10] = '{2'b00, 1'b1, 2'b00, '0,  1'b1, 1'b0, ga,  1'b1};
    tbl[11] = '{2'b00, 1'b1, 2'b00, '0,  1'b0, 1'b0, '0,  1'b0};

    // Reset with both requesters valid.
    rst      = 1'b1;
    req_vld  = 2'b11;
    req_data = {bb, ba};
    resp_rdy = 1'b0;
    flush    = 1'b0;
    #3;
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_g_a", 32'(g_a), 32'd0);
    chk("rst_resp_vld", 32'(resp_vld), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    next();
    next();
    chk("rst_req_rdy2", 32'(req_rdy), 32'd0);
    rst = 1'b0;

    // Single issue and round-robin fairness.
    for (int r = 0; r < 12; r++) begin
      req_vld  = tbl[r].vld;
      resp_rdy = tbl[r].rr;
      #3;
      chk($sformatf("row%0d_req_rdy", r), 32'(req_rdy), 32'(tbl[r].e_rdy));
      chk($sformatf("row%0d_g_a", r), 32'(g_a), 32'(tbl[r].e_ga));
      chk($sformatf("row%0d_resp_vld", r), 32'(resp_vld), 32'(tbl[r].e_rv));
      chk($sformatf("row%0d_resp_id", r), 32'(resp_id), 32'(tbl[r].e_id));
      chk($sformatf("row%0d_resp_data", r), 32'(resp_data), 32'(tbl[r].e_rd));
      chk($sformatf("row%0d_busy", r), 32'(busy), 32'(tbl[r].e_busy));
      chk($sformatf("row%0d_flush_done", r), 32'(flush_done), 32'd0);
      next();
    end

    // Backpressure: only four credits with the consumer stalled.
    exp_q.delete();
    req_vld  = 2'b01;
    resp_rdy = 1'b0;
    nissue   = 0;
    drive0();
    for (int c = 0; c < 8; c++) begin
      #3;
      chk($sformatf("bp%0d_req_rdy", c), 32'(req_rdy), (c < 4) ? 32'd1 : 32'd0);
      chk($sformatf("bp%0d_resp_vld", c), 32'(resp_vld), (c >= 2) ? 32'd1 : 32'd0);
      sb_sample();
      if (req_rdy[0]) begin
        nissue++;
        k++;
      end
      next();
      drive0();
    end
    chk("bp_issues", 32'(nissue), 32'd4);
    resp_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #3;
      if (c == 0) chk("bp_release_rdy0", 32'(req_rdy), 32'd0);
      if (c == 1) chk("bp_release_rdy1", 32'(req_rdy), 32'd1);
      sb_sample();
      if (req_rdy[0]) k++;
      next();
      drive0();
    end
    drain(20);

    // Flush with two batches outstanding.
    req_vld  = 2'b01;
    resp_rdy = 1'b1;
    for (int c = 0; c < 7; c++) begin
      flush = (c == 1);
      drive0();
      #3;
      case (c)
        0, 1: chk($sformatf("fl%0d_req_rdy", c), 32'(req_rdy), 32'd1);
        2, 3, 4, 5: chk($sformatf("fl%0d_req_rdy", c), 32'(req_rdy), 32'd0);
        default: chk($sformatf("fl%0d_req_rdy", c), 32'(req_rdy), 32'd1);
      endcase
      chk($sformatf("fl%0d_flush_done", c), 32'(flush_done), (c == 5) ? 32'd1 : 32'd0);
      if (c == 3) chk("fl3_resp_vld", 32'(resp_vld), 32'd1);
      if (c == 4) chk("fl4_busy", 32'(busy), 32'd0);
      sb_sample();
      if (req_rdy[0]) k++;
      next();
    end
    flush = 1'b0;
    drain(20);

    // Mid-operation reset with three responses queued.
    req_vld  = 2'b01;
    resp_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_vld = (c < 3) ? 2'b01 : 2'b00;
      drive0();
      #3;
      if (c < 3) chk($sformatf("mr%0d_req_rdy", c), 32'(req_rdy), 32'd1);
      k++;
      next();
    end
    #3;
    chk("mr_resp_vld_pre", 32'(resp_vld), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_resp_vld", 32'(resp_vld), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    req_vld  = 2'b11;
    resp_rdy = 1'b1;
    req_data = {bb, ba};
    #3;
    chk("mr_first_grant", 32'(req_rdy), 32'd1);
    chk("mr_g_a", 32'(g_a), 32'(ba));
    sb_sample();
    next();
    req_vld = 2'b00;
    #3;
    chk("mr_no_stale", 32'(resp_vld), 32'd0);
    next();
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
